// File: rtl/map_table_recovery_ctrl_pkg.sv
// Shared definitions for rename map table recovery: state encoding, copy geometry and tag width.
`ifndef CDB_BITS
`define CDB_BITS 7
`endif
`ifndef N_WAY
`define N_WAY 4
`endif

package map_table_recovery_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    COPY  = 2'd2,
    DONE  = 2'd3
  } recovery_state_t;

  localparam int NUM_REGS_DEF   = 32;
  localparam int COPY_WIDTH_DEF = 4;
  localparam int TAG_BITS       = `CDB_BITS;
  localparam int N_WAY_DEF      = `N_WAY;

endpackage

// File: rtl/map_table_recovery_ctrl_if.sv
// Retire-side recovery bus: flush/retire inputs, architecture-table read port,
// rename map table write port and pipeline hold controls.
interface map_table_recovery_ctrl_if #(
  parameter int NUM_REGS   = map_table_recovery_ctrl_pkg::NUM_REGS_DEF,
  parameter int TAG_BITS   = map_table_recovery_ctrl_pkg::TAG_BITS,
  parameter int COPY_WIDTH = map_table_recovery_ctrl_pkg::COPY_WIDTH_DEF,
  parameter int N_WAY      = map_table_recovery_ctrl_pkg::N_WAY_DEF
);
  localparam int IDX_BITS = $clog2(NUM_REGS);

  logic                                   flush_req;
  logic [N_WAY-1:0]                       ret_valid;
  logic [COPY_WIDTH-1:0][IDX_BITS-1:0]    arch_rd_idx;
  logic [COPY_WIDTH-1:0][TAG_BITS-1:0]    arch_rd_data;
  logic [COPY_WIDTH-1:0]                  rat_wr_en;
  logic [COPY_WIDTH-1:0][IDX_BITS-1:0]    rat_wr_idx;
  logic [COPY_WIDTH-1:0][TAG_BITS-1:0]    rat_wr_tag;
  logic                                   stall;
  logic                                   retire_hold;
  logic                                   freelist_restore;
  logic                                   recovery_done;
  logic                                   busy;

  modport master (
    input  flush_req, ret_valid, arch_rd_data,
    output arch_rd_idx, rat_wr_en, rat_wr_idx, rat_wr_tag,
           stall, retire_hold, freelist_restore, recovery_done, busy
  );

  modport slave (
    output flush_req, ret_valid, arch_rd_data,
    input  arch_rd_idx, rat_wr_en, rat_wr_idx, rat_wr_tag,
           stall, retire_hold, freelist_restore, recovery_done, busy
  );
endinterface

// File: rtl/map_table_recovery_ctrl.sv
// Restores the speculative rename map table from the architectural map table after a flush.
//   state | meaning
//   IDLE  | no recovery in progress, all outputs low
//   DRAIN | one cycle for flush-cycle retire writes to land; free list restore pulse
//   COPY  | COPY_WIDTH entries per cycle copied arch table -> rename map table
//   DONE  | one-cycle recovery_done, pipeline still held
module map_table_recovery_ctrl #(
  parameter int NUM_REGS   = map_table_recovery_ctrl_pkg::NUM_REGS_DEF,
  parameter int TAG_BITS   = map_table_recovery_ctrl_pkg::TAG_BITS,
  parameter int COPY_WIDTH = map_table_recovery_ctrl_pkg::COPY_WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  map_table_recovery_ctrl_if.master  bus
);
  import map_table_recovery_ctrl_pkg::*;

  localparam int                  IDX_BITS = $clog2(NUM_REGS);
  localparam logic [IDX_BITS-1:0] STEP     = IDX_BITS'(COPY_WIDTH);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_REGS - COPY_WIDTH);

  recovery_state_t     state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;

  logic [COPY_WIDTH-1:0][IDX_BITS-1:0] idx_lanes;
  logic [COPY_WIDTH-1:0][TAG_BITS-1:0] wr_tag;
  logic [COPY_WIDTH-1:0]               wr_en;
  logic                                hold;
  logic                                fl_restore;
  logic                                done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = COPY;
        idx_d   = '0;
      end
      COPY: begin
        idx_d = idx_q + STEP;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new flush mid-recovery invalidates everything copied so far.
    if (bus.flush_req && (state_q != IDLE)) begin
      state_d = DRAIN;
      idx_d   = '0;
    end
  end

  always_comb begin
    idx_lanes  = '0;
    wr_tag     = '0;
    wr_en      = '0;
    hold       = 1'b0;
    fl_restore = 1'b0;
    done       = 1'b0;
    case (state_q)
      DRAIN: begin
        hold       = 1'b1;
        fl_restore = 1'b1;
      end
      COPY: begin
        hold = 1'b1;
        for (int k = 0; k < COPY_WIDTH; k++) begin
          idx_lanes[k] = idx_q + IDX_BITS'(k);
          wr_tag[k]    = bus.arch_rd_data[k];
          wr_en[k]     = 1'b1;
        end
      end
      DONE: begin
        hold = 1'b1;
        done = 1'b1;
      end
      default: begin
        hold = 1'b0;
      end
    endcase
  end

  assign bus.arch_rd_idx      = idx_lanes;
  assign bus.rat_wr_idx       = idx_lanes;
  assign bus.rat_wr_tag       = wr_tag;
  assign bus.rat_wr_en        = wr_en;
  assign bus.stall            = hold;
  assign bus.retire_hold      = hold;
  assign bus.freelist_restore = fl_restore;
  assign bus.recovery_done    = done;
  assign bus.busy             = (state_q != IDLE);

endmodule

// File: doc/map_table_recovery_ctrl.md
# map_table_recovery_ctrl

Sequencer that restores the speculative rename map table from the architectural map table after a branch mispredict or exception flush at retire. It sits beside the architecture table in the retire stage. It drains the final in-flight retire writes, then copies the committed mapping into the rename map table at a fixed number of entries per cycle. While it works, it holds rename/dispatch and ROB retirement.

## Interface
- NUM_REGS, 32, architectural registers to restore; multiple of COPY_WIDTH, power of two
- TAG_BITS, `CDB_BITS, physical tag width
- COPY_WIDTH, 4, map entries copied per cycle
- N_WAY, `N_WAY, retire lanes observed
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush_req  in  1  one-cycle pulse from retire: mispredict or exception committed this cycle
- ret_valid  in  N_WAY  retire lanes writing the architecture table this cycle
- arch_rd_idx  out  COPY_WIDTH x clog2(NUM_REGS)  architecture-table read addresses
- arch_rd_data  in  COPY_WIDTH x TAG_BITS  combinational read data for arch_rd_idx
- rat_wr_en  out  COPY_WIDTH  rename map table write enables
- rat_wr_idx  out  COPY_WIDTH x clog2(NUM_REGS)  rename map table write addresses
- rat_wr_tag  out  COPY_WIDTH x TAG_BITS  restored tags
- stall  out  1  hold rename/dispatch
- retire_hold  out  1  block ROB retirement
- freelist_restore  out  1  one-cycle pulse: free list rebuilds from its retire pointer
- recovery_done  out  1  one-cycle pulse: map table consistent
- busy  out  1  state != IDLE

## Operation
- States: IDLE, DRAIN, COPY, DONE. State and counter are registers. All outputs decode from them.
- IDLE: all outputs 0. flush_req=1 → DRAIN.
- DRAIN: lasts exactly one cycle. Lets retire writes from the flush cycle land in the architecture table. stall=1, retire_hold=1, freelist_restore=1. Copy index idx is cleared to 0. Next state is COPY.
- COPY: for k in 0..COPY_WIDTH-1, arch_rd_idx[k]=rat_wr_idx[k]=idx+k, rat_wr_tag[k]=arch_rd_data[k], rat_wr_en[k]=1. idx advances by COPY_WIDTH each cycle. It wraps modulo NUM_REGS, with width clog2(NUM_REGS). When idx = NUM_REGS-COPY_WIDTH, the next state is DONE. stall=1, retire_hold=1.
- DONE: lasts one cycle. recovery_done=1. stall=1 and retire_hold=1 are still high this cycle. Next state is IDLE.
- Register 0 is copied like any other entry; no special case.
- flush_req in DRAIN, COPY or DONE restarts the sequence: next state DRAIN, idx cleared, freelist_restore pulses again.
- ret_valid=1 while retire_hold=1 is a protocol violation. The bench flags it with an assertion; the RTL ignores it.
- Reset in any state → IDLE, idx=0, all outputs 0 the following cycle. No partial writes after reset.

## Timing
- Flush sampled at edge T0:
  - DRAIN during T0..T1
  - COPY during T1..T1+NUM_REGS/COPY_WIDTH
  - DONE for one cycle after that
- Total busy cycles = NUM_REGS/COPY_WIDTH + 2. Defaults give 10.
- stall, retire_hold and busy rise the cycle after flush_req. They fall the cycle after recovery_done.
- Rename map table writes commit at the edge ending each COPY cycle. The table is fully restored at the edge ending the last COPY cycle, one cycle before recovery_done falls.
- Architecture-table read is combinational, same cycle. No read latency is modelled.

## Structure
- Shared package (existing core package):
  - recovery_state_t enum {IDLE, DRAIN, COPY, DONE}
  - COPY_WIDTH and NUM_REGS defaults
  - TAG_BITS alias of `CDB_BITS
- Single module. The copy counter is inline; no sub-module is warranted.
- The architecture table needs a COPY_WIDTH-port combinational read added. That change belongs to the architecture table, not this block.

## Test plan
- Reset then idle for 5 cycles → all outputs 0, busy=0.
- Architecture table holds tag i+1 for reg i; pulse flush_req at T0 → DRAIN at T1 with freelist_restore=1; 8 COPY cycles write regs 0-3, 4-7, …, 28-31 with tags 1..32; recovery_done in cycle 10 only; stall deasserted from cycle 11.
- Retire lane writes reg 5 → tag 40 in the flush cycle → restored rename map table entry 5 equals 40, not 6.
- Second flush_req during the 4th COPY cycle → idx restarts at 0; DRAIN re-entered; freelist_restore pulses twice total; full 10-cycle sequence completes from the second flush.
- reset asserted during the 3rd COPY cycle → next cycle IDLE, rat_wr_en=0, no recovery_done; a new flush afterwards completes normally.
- Scoreboard check across random arch-table contents and COPY_WIDTH ∈ {1,4,8} → rename map table equals architecture table at recovery_done.
